// File: rtl/beat_frame_serializer.sv
// Framed byte serializer for the debug read path.
// Consumes BEATS_PER_FRAME wide RAM read beats and emits them as a UART byte
// stream: HEADER0, HEADER1, frame_id, payload (LSB byte of each beat first),
// then an 8-bit additive checksum over frame_id and the payload.
module beat_frame_serializer #(
  parameter int          DATA_BYTE_WIDTH = 32,
  parameter int          BEATS_PER_FRAME = 16,
  parameter int          BEAT_CNT_WIDTH  = 4,
  parameter logic [7:0]  HEADER0         = 8'h55,
  parameter logic [7:0]  HEADER1         = 8'hAA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [7:0]                   frame_id,
  input  logic [DATA_BYTE_WIDTH*8-1:0] beat_data,
  input  logic                         beat_valid,
  output logic                         beat_ready,
  output logic [7:0]                   byte_data,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int BEAT_W     = DATA_BYTE_WIDTH * 8;
  localparam int BYTE_CNT_W = (DATA_BYTE_WIDTH > 1) ? $clog2(DATA_BYTE_WIDTH) : 1;
  localparam logic [BYTE_CNT_W-1:0]     LAST_BYTE = BYTE_CNT_W'(DATA_BYTE_WIDTH - 1);
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BEATS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    ID,
    LOAD,
    SHIFT,
    CSUM,
    DONE
  } state_t;

  state_t                    state;
  logic [7:0]                id_q;
  logic [7:0]                acc;
  logic [BEAT_W-1:0]         shreg;
  logic [BYTE_CNT_W-1:0]     byte_cnt;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
  logic [BEAT_W-1:0]         shreg_next;
  logic                      accept;

  // Modulo-256 checksum accumulation; wrap is intentional.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign shreg_next = shreg >> 8;
  assign accept     = byte_valid && byte_ready;

  // Beat handshake is a pure state decode so it never depends on beat_valid.
  always_comb begin
    beat_ready = (state == LOAD);
  end

  // Frame FSM; byte_data/byte_valid/frame_done/busy are registered alongside
  // the state so the next byte is ready on the same edge the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      byte_cnt   <= '0;
      beat_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            id_q       <= frame_id;
            acc        <= 8'h00;
            byte_cnt   <= '0;
            beat_cnt   <= '0;
            byte_data  <= HEADER0;
            byte_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= HDR0;
          end
        end
        HDR0: begin
          if (accept) begin
            byte_data <= HEADER1;
            state     <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            byte_data <= id_q;
            state     <= ID;
          end
        end
        ID: begin
          if (accept) begin
            acc        <= id_q;
            byte_valid <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (beat_valid) begin
            shreg      <= beat_data;
            byte_cnt   <= '0;
            byte_data  <= beat_data[7:0];
            byte_valid <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            acc       <= csum_add(acc, byte_data);
            shreg     <= shreg_next;
            byte_cnt  <= byte_cnt + 1'b1;
            byte_data <= shreg_next[7:0];
            if (byte_cnt == LAST_BYTE) begin
              if (beat_cnt < LAST_BEAT) begin
                beat_cnt   <= beat_cnt + 1'b1;
                byte_valid <= 1'b0;
                state      <= LOAD;
              end else begin
                // Checksum must include the byte being accepted right now.
                byte_data <= csum_add(acc, byte_data);
                state     <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept) begin
            byte_valid <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          byte_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_frame_serializer.sv
// Scoreboard bench for beat_frame_serializer: each frame's expected byte
// stream is queued when the frame is set up and popped on every accepted byte.
module tb_beat_frame_serializer;

  localparam int DBW = 32;
  localparam int BPF = 16;
  localparam int BW  = DBW * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [7:0]    frame_id;
  logic [BW-1:0] beat_data;
  logic          beat_valid;
  logic          beat_ready;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          frame_done;
  logic          busy;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beat_frame_serializer #(
    .DATA_BYTE_WIDTH(DBW),
    .BEATS_PER_FRAME(BPF),
    .BEAT_CNT_WIDTH (4),
    .HEADER0        (8'h55),
    .HEADER1        (8'hAA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .frame_id   (frame_id),
    .beat_data  (beat_data),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one frame. ff selects all-0xFF payload (else byte k = k mod 256);
  // bp toggles byte_ready; starve_beat/busy_beat/rst_byte < 0 disable those events.
  task automatic run_frame(input logic [7:0] id, input bit ff, input bit bp,
                           input int starve_beat, input int busy_beat, input int rst_byte);
    logic [BW-1:0] beats[BPF];
    logic [7:0]    sum;
    logic [7:0]    b8;
    int            bi, nbytes, cyc, starve_cnt;
    bit            injected, done, do_rst, got_done;
    logic          pv, pr;
    logic [7:0]    pd;

    sum = id;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(id);
    for (int b = 0; b < BPF; b++) begin
      for (int j = 0; j < DBW; j++) begin
        b8 = ff ? 8'hFF : 8'((b * DBW + j) % 256);
        beats[b][8*j +: 8] = b8;
        exp_q.push_back(b8);
        sum = sum + b8;
      end
    end
    exp_q.push_back(sum);

    bi = 0; nbytes = 0; cyc = 0; starve_cnt = 0;
    injected = 0; done = 0; do_rst = 0; got_done = 0;
    pv = 0; pr = 0; pd = 8'h00;

    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_id    = id;
    byte_ready  = 1'b1;
    beat_valid  = 1'b0;

    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      frame_start = 1'b0;
      if (do_rst) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beat_ready", 32'(beat_ready), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        beat_valid = 1'b0;
        exp_q.delete();
        repeat (20) begin
          @(negedge clk);
          check("post_rst_frame_done", 32'(frame_done), 32'd0);
          check("post_rst_byte_valid", 32'(byte_valid), 32'd0);
        end
        done = 1;
        break;
      end
      byte_ready = bp ? 1'(cyc % 2) : 1'b1;
      beat_data  = beats[(bi < BPF) ? bi : BPF - 1];
      beat_valid = (bi < BPF);
      if (bi == starve_beat && starve_cnt < 10 && (starve_cnt > 0 || beat_ready)) begin
        beat_valid = 1'b0;
        starve_cnt++;
        check("starve_beat_ready", 32'(beat_ready), 32'd1);
        check("starve_byte_valid", 32'(byte_valid), 32'd0);
      end
      if (bi == busy_beat && !injected) begin
        frame_start = 1'b1;
        frame_id    = 8'h33;
        injected    = 1;
      end
      if (cyc == 1) check("first_hdr_valid", 32'(byte_valid), 32'd1);

      @(negedge clk);
      if (pv && !pr) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_data", 32'(byte_data), 32'(pd));
      end
      if (beat_valid && beat_ready) bi++;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(byte_data), 32'hFFFF_FFFF);
        else check($sformatf("byte%0d", nbytes), 32'(byte_data), 32'(exp_q.pop_front()));
        nbytes++;
        if (rst_byte >= 0 && nbytes == 3 + rst_byte) do_rst = 1;
      end
      pv = byte_valid; pr = byte_ready; pd = byte_data;
      if (frame_done) begin
        check("left_in_queue", 32'(exp_q.size()), 32'd0);
        check("byte_count", 32'(nbytes), 32'(3 + BPF * DBW + 1));
        if (!bp && starve_beat < 0) check("frame_cycles", 32'(cyc), 32'd533);
        got_done = 1;
        done = 1;
      end
    end

    if (!done) check("timeout", 32'd0, 32'd1);
    frame_start = 1'b0;
    beat_valid  = 1'b0;
    byte_ready  = 1'b1;
    if (got_done) begin
      repeat (40) begin
        @(negedge clk);
        check("idle_frame_done", 32'(frame_done), 32'd0);
        check("idle_byte_valid", 32'(byte_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    frame_id    = 8'h00;
    beat_data   = '0;
    beat_valid  = 1'b0;
    byte_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_byte_valid", 32'(byte_valid), 32'd0);
    check("reset_byte_data", 32'(byte_data), 32'd0);
    check("reset_beat_ready", 32'(beat_ready), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_frame(8'h07, 1'b0, 1'b0, -1, -1, -1);   // basic frame
    run_frame(8'h00, 1'b1, 1'b0, -1, -1, -1);   // all-0xFF payload
    run_frame(8'h07, 1'b0, 1'b1, -1, -1, -1);   // byte_ready toggling
    run_frame(8'h07, 1'b0, 1'b0,  5, -1, -1);   // beat starvation at beat 5
    run_frame(8'h07, 1'b0, 1'b0, -1,  3, -1);   // frame_start while busy
    run_frame(8'h07, 1'b0, 1'b0, -1, -1, 100);  // reset mid-frame
    run_frame(8'h07, 1'b0, 1'b0, -1, -1, -1);   // fresh frame after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_frame_serializer.md
# beat_frame_serializer

Downstream byte framer for the debug read path: accepts wide RAM read beats (one 32-byte window per beat, as returned by the AXI window RAM) and turns one burst of beats into a framed UART byte stream. It feeds the UART transmitter over a byte valid/ready handshake. It adds a two-byte sync header, a frame ID and a trailing 8-bit additive checksum, so the PC side can re-align on window dumps.

## Interface
- DATA_BYTE_WIDTH, 32, bytes per input beat; beat width is DATA_BYTE_WIDTH*8.
- BEATS_PER_FRAME, 16, beats consumed per frame.
- BEAT_CNT_WIDTH, 4, width of beat counter; must satisfy 2**BEAT_CNT_WIDTH >= BEATS_PER_FRAME.
- HEADER0, 8'h55, first sync byte.
- HEADER1, 8'hAA, second sync byte.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle request to emit a frame; sampled only in IDLE.
- frame_id  in  8  frame ID, captured with frame_start.
- beat_data  in  DATA_BYTE_WIDTH*8  read beat, byte 0 = bits [7:0].
- beat_valid  in  1  beat_data valid.
- beat_ready  out  1  serializer accepts a beat this cycle.
- byte_data  out  8  output byte to UART TX.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  UART TX accepts byte this cycle.
- frame_done  out  1  one-cycle pulse after the checksum byte is accepted.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame on the wire: HEADER0, HEADER1, frame_id, then BEATS_PER_FRAME*DATA_BYTE_WIDTH payload bytes, then the checksum. Default frame is 516 bytes.
- Payload order: beats in arrival order. Within a beat, LSB byte first (bits [7:0], then [15:8], and so on).
- Checksum = (frame_id + sum of all payload bytes) mod 256. Header bytes are excluded.
- FSM states and transitions:
  - IDLE: frame_start → HDR0. Capture frame_id; clear the accumulator and counters.
  - HDR0: on accept → HDR1.
  - HDR1: on accept → ID.
  - ID: on accept → LOAD. Accumulator = frame_id.
  - LOAD: beat_ready=1. On beat_valid → SHIFT. Load shift register; byte_cnt=0.
  - SHIFT: byte_data = shreg[7:0]. On accept: shift right 8, add the byte to the accumulator, byte_cnt++. At byte_cnt==DATA_BYTE_WIDTH-1: go to LOAD if beat_cnt<BEATS_PER_FRAME-1 (beat_cnt++), otherwise go to CSUM.
  - CSUM: byte_data = accumulator. On accept → DONE.
  - DONE: frame_done=1 for one cycle → IDLE.
- "Accept" means byte_valid && byte_ready in the same cycle.
- byte_valid=1 exactly in HDR0, HDR1, ID, SHIFT, CSUM.
- beat_ready=1 only in LOAD. A beat_valid outside LOAD is neither consumed nor buffered.
- frame_start while busy is ignored; no queuing.
- Arithmetic: the accumulator is 8 bits and wraps silently. byte_cnt width is clog2(DATA_BYTE_WIDTH).

## Timing
- Reset values: byte_valid=0, byte_data=0, beat_ready=0, frame_done=0, busy=0, state=IDLE.
- Reset asserted mid-frame aborts the frame on the next edge. No frame_done is issued, and no further bytes are emitted.
- frame_start at cycle 0 → byte_valid=1 with HEADER0 at cycle 1.
- byte_data and byte_valid come from registers or state only. There is no combinational path from byte_ready or beat_valid to any output except beat_ready, which is decoded from state.
- While byte_valid && !byte_ready, byte_data holds stable and the state does not advance.
- Throughput with byte_ready tied high:
  - one byte per cycle;
  - one LOAD cycle per beat (byte_valid=0 in that cycle);
  - default frame: 3 + 16*(1+32) + 1 + 1 = 533 cycles from frame_start to frame_done.
- The last-byte-of-beat and last-beat conditions are evaluated on the same accept edge. A 1-beat frame (BEATS_PER_FRAME=1) goes SHIFT→CSUM directly.

## Test plan
- Basic frame:
  - Stimulus: frame_id=0x07; 16 beats, payload byte k = k mod 256; byte_ready=1; beat_valid=1.
  - Response: bytes 55 AA 07 00 01 … FF 00 … FF, then checksum 0x07; frame_done one cycle after the checksum is accepted; 533 cycles total.
- All-0xFF payload:
  - Stimulus: frame_id=0x00, every payload byte 0xFF.
  - Response: checksum 0x00.
- Output backpressure:
  - Stimulus: byte_ready toggled 1/0 every cycle.
  - Response: byte_data constant while stalled; byte sequence identical to the basic case.
- Input starvation:
  - Stimulus: beat_valid held low 10 cycles at beat 5.
  - Response: remains in LOAD with byte_valid=0 and no duplicated or skipped bytes; beat_ready high throughout the stall.
- Busy behaviour:
  - Stimulus: frame_start=1 with id 0x33 during beat 3 of a frame with id 0x07.
  - Response: ignored; the current frame completes with id 0x07; no second frame.
- Reset mid-frame:
  - Stimulus: rst pulsed at payload byte 100.
  - Response: next cycle byte_valid=0, busy=0, beat_ready=0, no frame_done. A fresh frame_start then yields a correct complete frame.
